yv_gather_ctrl: RTL and testbench



---
 rtl/yv_gather_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_yv_gather_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/yv_gather_ctrl.sv
// Y/V gather controller: fetches packed Y column-info words, decodes lanes into
// V-bank reads and serialises bank conflicts over as many issue cycles as needed.
module yv_gather_ctrl #(
  parameter int N_LANES    = 4,
  parameter int N_BANKS    = 4,
  parameter int BANK_PORTS = 2,
  parameter int ADDR_W     = 9,
  parameter int Y_ADDR_W   = 11,
  parameter int Y_FIRST    = 63,
  parameter int Y_LAST     = 2047,
  localparam int BANK_W    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  localparam int N_SLOTS   = N_BANKS * BANK_PORTS,
  localparam int SEL_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [16*N_LANES-1:0]       y_col_info,
  input  logic                        out_ready,
  output logic [Y_ADDR_W-1:0]         Y_addressline_1,
  output logic                        y_rd_en,
  output logic [N_SLOTS*ADDR_W-1:0]   v_bank_addr,
  output logic [N_SLOTS-1:0]          v_bank_en,
  output logic [N_LANES*SEL_W-1:0]    lane_sel,
  output logic [N_LANES-1:0]          lane_valid,
  output logic [N_LANES-1:0]          row_mark,
  output logic                        switch_from_fifo1_fifo2,
  output logic                        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [Y_ADDR_W-1:0] y_ptr, y_ptr_n;
  logic [N_LANES-1:0]  pending;
  logic [N_LANES-1:0]  marks;
  logic                first_q;

  logic [BANK_W-1:0]   bank_in [N_LANES];
  logic [ADDR_W-1:0]   col_in  [N_LANES];
  logic [N_LANES-1:0]  mark_in;

  logic [BANK_W-1:0]   bank_q  [N_LANES];
  logic [ADDR_W-1:0]   col_q   [N_LANES];

  logic [N_LANES-1:0]  grant;
  logic [N_SLOTS-1:0]  en_n;
  logic [ADDR_W-1:0]   addr_n  [N_SLOTS];
  logic [SEL_W-1:0]    sel_n   [N_LANES];
  logic                issue_go;
  logic                leave_issue;

  // Only the bank/col/marker fields of each entry are consumed.
  logic unused_y_bits;
  always_comb unused_y_bits = ^y_col_info;

  always_comb begin
    int unsigned bnum;
    mark_in = '0;
    bnum    = 0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      bank_in[i] = y_col_info[16*i +: BANK_W];
      col_in[i]  = y_col_info[16*i + BANK_W +: ADDR_W];
      bnum       = 32'(bank_in[i]);
      mark_in[i] = (&y_col_info[16*i + 13 +: 3]) || (bnum >= N_BANKS);
    end
  end

  assign issue_go = (state == S_ISSUE) && out_ready && enable;

  // Lanes claim ports of their bank in ascending lane order, port 0 first.
  always_comb begin
    int unsigned used [N_BANKS];
    int unsigned b;
    int unsigned s;
    grant = '0;
    en_n  = '0;
    b     = 0;
    s     = 0;
    for (int unsigned k = 0; k < N_BANKS; k++) used[k] = 0;
    for (int unsigned k = 0; k < N_SLOTS; k++) addr_n[k] = '0;
    for (int unsigned i = 0; i < N_LANES; i++) sel_n[i] = '0;
    if (issue_go) begin
      for (int unsigned i = 0; i < N_LANES; i++) begin
        if (pending[i]) begin
          b = 32'(bank_q[i]);
          if (used[b] < BANK_PORTS) begin
            s         = b * BANK_PORTS + used[b];
            grant[i]  = 1'b1;
            en_n[s]   = 1'b1;
            addr_n[s] = col_q[i];
            sel_n[i]  = SEL_W'(s);
            used[b]   = used[b] + 1;
          end
        end
      end
    end
  end

  assign leave_issue = issue_go && ((pending & ~grant) == '0);

  always_comb begin
    state_n = state;
    y_ptr_n = y_ptr;
    case (state)
      S_IDLE:    if (enable) state_n = S_FETCH;
      S_FETCH:   state_n = S_WAIT;
      S_WAIT:    state_n = S_ISSUE;
      S_ISSUE:   if (leave_issue) state_n = S_ADVANCE;
      S_ADVANCE: begin
        if (y_ptr == Y_ADDR_W'(Y_LAST)) begin
          state_n = S_DONE;
        end else begin
          y_ptr_n = y_ptr + 1'b1;
          state_n = S_FETCH;
        end
      end
      S_DONE:    state_n = S_DONE;
      default:   state_n = S_IDLE;
    endcase
    if (!enable) begin
      state_n = S_IDLE;
      y_ptr_n = y_ptr;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state                   <= S_IDLE;
      y_ptr                   <= Y_ADDR_W'(Y_FIRST);
      pending                 <= '0;
      marks                   <= '0;
      first_q                 <= 1'b0;
      Y_addressline_1         <= '0;
      y_rd_en                 <= 1'b0;
      v_bank_addr             <= '0;
      v_bank_en               <= '0;
      lane_sel                <= '0;
      lane_valid              <= '0;
      row_mark                <= '0;
      switch_from_fifo1_fifo2 <= 1'b0;
      done                    <= 1'b0;
      for (int unsigned i = 0; i < N_LANES; i++) begin
        bank_q[i] <= '0;
        col_q[i]  <= '0;
      end
    end else begin
      state   <= state_n;
      y_ptr   <= y_ptr_n;
      y_rd_en <= (state_n == S_FETCH);
      done    <= (state_n == S_DONE);

      if (state_n == S_FETCH)     Y_addressline_1 <= y_ptr_n;
      else if (state_n == S_IDLE) Y_addressline_1 <= '0;

      if (state == S_WAIT) begin
        for (int unsigned i = 0; i < N_LANES; i++) begin
          bank_q[i] <= bank_in[i];
          col_q[i]  <= col_in[i];
        end
        pending <= ~mark_in;
        marks   <= mark_in;
        first_q <= 1'b1;
      end else if (state_n == S_IDLE) begin
        pending <= '0;
        first_q <= 1'b0;
      end else if (issue_go) begin
        pending <= pending & ~grant;
        first_q <= 1'b0;
      end

      v_bank_en  <= en_n;
      lane_valid <= grant;
      row_mark   <= (issue_go && first_q) ? marks : '0;

      for (int unsigned s = 0; s < N_SLOTS; s++) begin
        if (state_n == S_IDLE)  v_bank_addr[s*ADDR_W +: ADDR_W] <= '0;
        else if (en_n[s])       v_bank_addr[s*ADDR_W +: ADDR_W] <= addr_n[s];
      end
      for (int unsigned i = 0; i < N_LANES; i++) begin
        if (state_n == S_IDLE)  lane_sel[i*SEL_W +: SEL_W] <= '0;
        else if (grant[i])      lane_sel[i*SEL_W +: SEL_W] <= sel_n[i];
      end

      if (state_n == S_IDLE)       switch_from_fifo1_fifo2 <= 1'b0;
      else if (state == S_ADVANCE) switch_from_fifo1_fifo2 <= ~switch_from_fifo1_fifo2;
    end
  end

endmodule

// File: tb/tb_yv_gather_ctrl.sv
// Directed bench for yv_gather_ctrl: dual-port instance for the main flow,
// single-port instance with a short Y range for serialisation and done.
module tb_yv_gather_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic out_ready;
  logic en_a, en_b;
  logic [63:0] y_a, y_b;

  logic [10:0] addr_a, addr_b;
  logic        rd_a, rd_b;
  logic [71:0] vaddr_a;
  logic [35:0] vaddr_b;
  logic [7:0]  ven_a;
  logic [3:0]  ven_b;
  logic [11:0] sel_a;
  logic [7:0]  sel_b;
  logic [3:0]  lv_a, lv_b, rm_a, rm_b;
  logic        sw_a, sw_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  yv_gather_ctrl #(
    .N_LANES(4), .N_BANKS(4), .BANK_PORTS(2), .ADDR_W(9),
    .Y_ADDR_W(11), .Y_FIRST(63), .Y_LAST(2047)
  ) u_dut_a (
    .clock(clock), .reset(reset), .enable(en_a), .y_col_info(y_a),
    .out_ready(out_ready), .Y_addressline_1(addr_a), .y_rd_en(rd_a),
    .v_bank_addr(vaddr_a), .v_bank_en(ven_a), .lane_sel(sel_a),
    .lane_valid(lv_a), .row_mark(rm_a),
    .switch_from_fifo1_fifo2(sw_a), .done(done_a)
  );

  yv_gather_ctrl #(
    .N_LANES(4), .N_BANKS(4), .BANK_PORTS(1), .ADDR_W(9),
    .Y_ADDR_W(11), .Y_FIRST(63), .Y_LAST(64)
  ) u_dut_b (
    .clock(clock), .reset(reset), .enable(en_b), .y_col_info(y_b),
    .out_ready(out_ready), .Y_addressline_1(addr_b), .y_rd_en(rd_b),
    .v_bank_addr(vaddr_b), .v_bank_en(ven_b), .lane_sel(sel_b),
    .lane_valid(lv_b), .row_mark(rm_b),
    .switch_from_fifo1_fifo2(sw_b), .done(done_b)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; out_ready = 1'b1;
    en_a = 1'b0; en_b = 1'b0; y_a = '0; y_b = '0;
    repeat (3) step;
    chk("rst_rd_a", rd_a, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_ven_a", ven_a, 0);
    chk("rst_lv_a", lv_a, 0);
    chk("rst_sw_a", sw_a, 0);
    chk("rst_done_b", done_b, 0);
    reset = 1'b1;
    step;

    // Word 63: banks 0..3, cols 5..8
    y_a = 64'h0023_001E_0019_0014;
    en_a = 1'b1;
    step;
    chk("w1_rd", rd_a, 1);
    chk("w1_addr", addr_a, 63);
    step;
    chk("w1_rd_once", rd_a, 0);
    step;
    step;
    chk("w1_ven", ven_a, 8'h55);
    chk("w1_a0", vaddr_a[0 +: 9], 5);
    chk("w1_a2", vaddr_a[18 +: 9], 6);
    chk("w1_a4", vaddr_a[36 +: 9], 7);
    chk("w1_a6", vaddr_a[54 +: 9], 8);
    chk("w1_sel", sel_a, 12'hD10);
    chk("w1_lv", lv_a, 4'b1111);
    chk("w1_rm", rm_a, 0);

    // Word 64: banks 1,1,1,2 -> two issue rounds
    y_a = 64'h0012_000D_0009_0005;
    step;
    chk("w1_sw", sw_a, 1);
    chk("w2_rd", rd_a, 1);
    chk("w2_addr", addr_a, 64);
    chk("w2_ven_idle", ven_a, 0);
    step;
    step;
    step;
    chk("w2i1_ven", ven_a, 8'h1C);
    chk("w2i1_a2", vaddr_a[18 +: 9], 1);
    chk("w2i1_a3", vaddr_a[27 +: 9], 2);
    chk("w2i1_a4", vaddr_a[36 +: 9], 4);
    chk("w2i1_lv", lv_a, 4'b1011);
    chk("w2i1_sel0", sel_a[2:0], 2);
    chk("w2i1_sel1", sel_a[5:3], 3);
    chk("w2i1_sel3", sel_a[11:9], 4);
    step;
    chk("w2i2_ven", ven_a, 8'h04);
    chk("w2i2_a2", vaddr_a[18 +: 9], 3);
    chk("w2i2_lv", lv_a, 4'b0100);
    chk("w2i2_sel2", sel_a[8:6], 2);

    // Word 65: lane 2 is a marker
    y_a = 64'h0033_E000_002D_0028;
    step;
    chk("w3_addr", addr_a, 65);
    chk("w2_sw", sw_a, 0);
    step;
    step;
    step;
    chk("w3_rm", rm_a, 4'b0100);
    chk("w3_lv", lv_a, 4'b1011);
    chk("w3_ven", ven_a, 8'h45);
    chk("w3_a0", vaddr_a[0 +: 9], 10);
    chk("w3_a2", vaddr_a[18 +: 9], 11);
    chk("w3_a6", vaddr_a[54 +: 9], 12);

    // Word 66: all lanes marked
    y_a = 64'hE000_E000_E000_E000;
    step;
    chk("w3_rm_pulse", rm_a, 0);
    chk("w4_addr", addr_a, 66);
    step;
    step;
    step;
    chk("w4_rm", rm_a, 4'b1111);
    chk("w4_ven", ven_a, 0);
    chk("w4_lv", lv_a, 0);

    // Word 67: banks 0,0,0,1, stall after first round, then abort
    y_a = 64'h0011_000C_0008_0004;
    step;
    chk("w4_one_issue", rd_a, 1);
    chk("w5_addr", addr_a, 67);
    step;
    step;
    step;
    chk("w5i1_ven", ven_a, 8'h07);
    chk("w5i1_a0", vaddr_a[0 +: 9], 1);
    chk("w5i1_a1", vaddr_a[9 +: 9], 2);
    chk("w5i1_a2", vaddr_a[18 +: 9], 4);
    chk("w5i1_lv", lv_a, 4'b1011);
    out_ready = 1'b0;
    step;
    chk("stall1_ven", ven_a, 0);
    chk("stall1_lv", lv_a, 0);
    step;
    chk("stall2_ven", ven_a, 0);
    step;
    chk("stall3_ven", ven_a, 0);
    chk("stall3_lv", lv_a, 0);
    en_a = 1'b0;
    out_ready = 1'b1;
    step;
    chk("abort_ven", ven_a, 0);
    chk("abort_lv", lv_a, 0);
    chk("abort_rd", rd_a, 0);
    chk("abort_addr", addr_a, 0);
    chk("abort_vaddr", vaddr_a, 0);
    chk("abort_sel", sel_a, 0);
    chk("abort_rm", rm_a, 0);
    en_a = 1'b1;
    step;
    chk("refetch_rd", rd_a, 1);
    chk("refetch_addr", addr_a, 67);
    step;
    step;
    step;
    chk("w5r_i1_ven", ven_a, 8'h07);
    step;
    chk("w5r_i2_ven", ven_a, 8'h01);
    chk("w5r_i2_a0", vaddr_a[0 +: 9], 3);
    chk("w5r_i2_lv", lv_a, 4'b0100);
    step;
    chk("w6_addr", addr_a, 68);
    en_a = 1'b0;

    // Single-port instance: all lanes on bank 0, Y_LAST = 64
    y_b = 64'h0010_000C_0008_0004;
    en_b = 1'b1;
    step;
    chk("b_rd", rd_b, 1);
    chk("b_addr", addr_b, 63);
    step;
    step;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("b_w1_lv", lv_b, 4'b0001 << i);
      chk("b_w1_ven", ven_b, 4'b0001);
      chk("b_w1_a0", vaddr_b[8:0], i + 1);
      chk("b_w1_sel", sel_b, 0);
    end
    step;
    chk("b_w2_addr", addr_b, 64);
    chk("b_w1_sw", sw_b, 1);
    chk("b_w2_lv_gap", lv_b, 0);
    step;
    step;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("b_w2_lv", lv_b, 4'b0001 << i);
      chk("b_w2_done_low", done_b, 0);
    end
    step;
    chk("b_done", done_b, 1);
    chk("b_w2_sw", sw_b, 0);
    chk("b_done_rd", rd_b, 0);
    repeat (3) step;
    chk("b_done_hold", done_b, 1);
    chk("b_done_nofetch", rd_b, 0);
    en_b = 1'b0;
    step;
    chk("b_done_clear", done_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
